// File: rtl/led_code_sequencer.sv
// Status LED arbiter/sequencer: grants the LED to the highest-priority valid requester
// and plays its code as N unit-long pulses followed by a dark gap.
//
//  state  | meaning
//  IDLE   | no sequence; led follows idle_led (1 cycle late); arbitrate every cycle
//  ON     | pulse high for one unit
//  OFF    | dark unit between pulses
//  GAP    | dark gap after last pulse; done + re-arbitration on its last cycle
module led_code_sequencer #(
    parameter int UNIT_CYCLES = 2_500_000,
    parameter int GAP_UNITS   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] code0,
    input  logic [3:0] code1,
    input  logic [3:0] code2,
    input  logic [3:0] code3,
    input  logic       idle_led,
    output logic       led,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done
);

    localparam int UW = $clog2(UNIT_CYCLES);
    localparam int GW = $clog2(GAP_UNITS + 1);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [UW-1:0] UNIT_PRE  = UW'(UNIT_CYCLES - 2);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_UNITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    state_t        r_state;
    logic [3:0]    r_pcnt;
    logic [UW-1:0] r_unit_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          r_led;
    logic [3:0]    r_grant;
    logic          r_busy;
    logic          r_done;

    logic [3:0] w_code [4];
    logic [3:0] w_valid;
    logic [3:0] w_win;
    logic [3:0] w_win_code;
    logic       w_any;
    logic       w_tick;

    assign w_code[0] = code0;
    assign w_code[1] = code1;
    assign w_code[2] = code2;
    assign w_code[3] = code3;

    always_comb begin
        w_win      = '0;
        w_win_code = '0;
        for (int i = 0; i < 4; i++) begin
            w_valid[i] = req[i] && (w_code[i] != 4'd0);
        end
        // Descending scan so the lowest valid index is the last (winning) assignment.
        for (int i = 3; i >= 0; i--) begin
            if (w_valid[i]) begin
                w_win      = '0;
                w_win[i]   = 1'b1;
                w_win_code = w_code[i];
            end
        end
    end

    assign w_any  = |w_valid;
    assign w_tick = (r_unit_cnt == UNIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pcnt     <= '0;
            r_unit_cnt <= '0;
            r_gap_cnt  <= '0;
            r_led      <= 1'b0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_led      <= idle_led;
                    r_unit_cnt <= '0;
                    r_gap_cnt  <= '0;
                    if (w_any) begin
                        r_state <= S_ON;
                        r_led   <= 1'b1;
                        r_grant <= w_win;
                        r_busy  <= 1'b1;
                        r_pcnt  <= w_win_code;
                    end
                end
                S_ON: begin
                    if (w_tick) begin
                        r_unit_cnt <= '0;
                        r_led      <= 1'b0;
                        if (r_pcnt > 4'd1) begin
                            r_pcnt  <= r_pcnt - 4'd1;
                            r_state <= S_OFF;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end
                    end else begin
                        r_unit_cnt <= r_unit_cnt + UW'(1);
                    end
                end
                S_OFF: begin
                    if (w_tick) begin
                        r_unit_cnt <= '0;
                        r_led      <= 1'b1;
                        r_state    <= S_ON;
                    end else begin
                        r_unit_cnt <= r_unit_cnt + UW'(1);
                    end
                end
                S_GAP: begin
                    // done is registered, so raise it one cycle ahead of the final GAP cycle.
                    r_done <= (r_unit_cnt == UNIT_PRE) && (r_gap_cnt == GAP_LAST);
                    if (w_tick) begin
                        r_unit_cnt <= '0;
                        if (r_gap_cnt == GAP_LAST) begin
                            r_gap_cnt <= '0;
                            if (w_any) begin
                                r_state <= S_ON;
                                r_led   <= 1'b1;
                                r_grant <= w_win;
                                r_pcnt  <= w_win_code;
                            end else begin
                                r_state <= S_IDLE;
                                r_led   <= idle_led;
                                r_grant <= '0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GW'(1);
                        end
                    end else begin
                        r_unit_cnt <= r_unit_cnt + UW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign led   = r_led;
    assign grant = r_grant;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_led_code_sequencer.sv
// Scoreboard bench for led_code_sequencer: stimulus queues expected sequences,
// a negedge monitor measures each played sequence and checks it at done.
module tb_led_code_sequencer;

    localparam int UC = 4;
    localparam int GU = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] code0, code1, code2, code3;
    logic       idle_led;
    logic       led;
    logic [3:0] grant;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] g;
        int         n;
        bit         b2b;
    } exp_t;
    exp_t exp_q[$];

    led_code_sequencer #(.UNIT_CYCLES(UC), .GAP_UNITS(GU)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .code0(code0), .code1(code1), .code2(code2), .code3(code3),
        .idle_led(idle_led), .led(led), .grant(grant), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] g, input int n, input bit b2b);
        exp_t e;
        e.g = g; e.n = n; e.b2b = b2b;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input logic [3:0] g, input int budget);
        int k = 0;
        while (grant !== g && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("grant_wait", int'(grant), int'(g));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", int'(busy), 0);
    endtask

    // Monitor: measures each sequence while busy, compares at done against the queue.
    bit m_prev_busy = 0, m_prev_done = 0, m_prev_led = 0, m_b2b = 0;
    int m_len = 0, m_pulses = 0, m_high = 0, m_run = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_busy = 0;
            m_prev_done = 0;
        end else begin
            if (busy) begin
                if (!m_prev_busy || m_prev_done) begin
                    m_len = 0; m_pulses = 0; m_high = 0; m_run = 0;
                    m_prev_led = 0;
                    m_b2b = m_prev_done;
                end
                m_len++;
                if (led) begin
                    m_high++;
                    m_run++;
                    if (!m_prev_led) m_pulses++;
                end else if (m_prev_led) begin
                    chk("pulse_width", m_run, UC);
                    m_run = 0;
                end
                m_prev_led = led;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual_grant=%0h required=none", grant);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("seq_grant", int'(grant), int'(e.g));
                        chk("seq_pulses", m_pulses, e.n);
                        chk("seq_length", m_len, (2 * e.n - 1) * UC + GU * UC);
                        chk("seq_high_cycles", m_high, e.n * UC);
                        chk("seq_back_to_back", int'(m_b2b), int'(e.b2b));
                    end
                end
            end else if (done) begin
                checks++;
                failures++;
                $display("FAIL done_without_busy actual=1 required=0");
            end
            m_prev_busy = busy;
            m_prev_done = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic       last;
        int         bad;

        // 1: reset with all requests high, then idle follow
        rst_n = 1'b0; req = 4'hF; idle_led = 1'b0;
        code0 = 4'd1; code1 = 4'd2; code2 = 4'd3; code3 = 4'd4;
        repeat (3) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        req = 4'h0;
        rst_n = 1'b1;
        pat = 8'b1011_0010;
        last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) chk("idle_follow", int'(led), int'(last));
            idle_led = pat[i];
            last = pat[i];
        end
        @(negedge clk);
        chk("idle_follow", int'(led), int'(last));
        idle_led = 1'b0;
        @(negedge clk);

        // 2: single code 3 on channel 2, one-cycle request
        push_exp(4'b0100, 3, 1'b0);
        req = 4'b0100; code2 = 4'd3;
        @(negedge clk);
        req = 4'b0000;
        chk("grant_latency", int'(grant), 4'b0100);
        chk("busy_latency", int'(busy), 1);
        chk("led_latency", int'(led), 1);
        wait_idle(100);
        chk("idle_grant", int'(grant), 0);
        repeat (2) @(negedge clk);

        // 3: simultaneous channels 1 and 3, back-to-back handover
        push_exp(4'b0010, 2, 1'b0);
        push_exp(4'b1000, 1, 1'b1);
        code1 = 4'd2; code3 = 4'd1;
        req = 4'b1010;
        @(negedge clk);
        chk("prio_grant", int'(grant), 4'b0010);
        req = 4'b1000;
        wait_grant(4'b1000, 100);
        req = 4'b0000;
        wait_idle(100);
        repeat (2) @(negedge clk);

        // 4: no pre-emption of channel 2 (code 5) by channel 0
        push_exp(4'b0100, 5, 1'b0);
        push_exp(4'b0001, 1, 1'b1);
        code2 = 4'd5; code0 = 4'd1;
        req = 4'b0100;
        @(negedge clk);
        chk("ch2_grant", int'(grant), 4'b0100);
        req = 4'b0000;
        repeat (10) @(negedge clk);
        req = 4'b0001;
        repeat (5) @(negedge clk);
        chk("no_preempt", int'(grant), 4'b0100);
        wait_grant(4'b0001, 100);
        req = 4'b0000;
        wait_idle(100);
        repeat (2) @(negedge clk);

        // 5: code 0 is not a request
        push_exp(4'b0010, 2, 1'b0);
        code0 = 4'd0; code1 = 4'd2;
        req = 4'b0011;
        @(negedge clk);
        chk("code0_skip", int'(grant), 4'b0010);
        req = 4'b0001;
        wait_idle(100);
        repeat (10) @(negedge clk);
        chk("code0_never_busy", int'(busy), 0);
        chk("code0_never_grant", int'(grant), 0);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // 6: async reset during the 2nd OFF of a code-4 sequence
        code3 = 4'd4;
        req = 4'b1000;
        @(negedge clk);
        chk("ch3_grant", int'(grant), 4'b1000);
        req = 4'b0000;
        repeat (13) @(negedge clk);
        chk("second_off_led", int'(led), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led", int'(led), 0);
        chk("async_grant", int'(grant), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (led !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000) bad++;
        end
        chk("no_residual", bad, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
